// File: rtl/ksa.sv
// rtl/ksa.sv - RC4 key-scheduling stage permuting a 256x8 single-port S memory in place.
// Optional macro KSA_CYCLE_COUNT_EN adds a 16-bit busy-cycle counter output.
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
`ifdef KSA_CYCLE_COUNT_EN
  ,
  output logic [15:0]            cycles
`endif
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_I,
    S_LAT_I,
    S_RD_J,
    S_LAT_J,
    S_WR_I,
    S_WR_J
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_i;
  logic [7:0]             r_j;
  logic [7:0]             r_si;
  logic [KW-1:0]          r_kidx;
  logic [8*KEY_BYTES-1:0] r_key;

  logic [7:0]             w_keybyte;
  logic [7:0]             w_jn;

  // Byte 0 of the key sits in the most significant position.
  always_comb begin
    w_keybyte = 8'd0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (r_kidx == KW'(k)) begin
        w_keybyte = r_key[8*(KEY_BYTES-1-k) +: 8];
      end
    end
  end

  assign w_jn = r_j + rddata + w_keybyte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      rdy     <= 1'b1;
      wren    <= 1'b0;
      addr    <= 8'd0;
      wrdata  <= 8'd0;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_si    <= 8'd0;
      r_kidx  <= '0;
      r_key   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          wren <= 1'b0;
          if (en) begin
            r_state <= S_RD_I;
            rdy     <= 1'b0;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_kidx  <= '0;
            r_key   <= key;
            addr    <= 8'd0;
          end
        end
        S_RD_I: begin
          r_state <= S_LAT_I;
        end
        S_LAT_I: begin
          r_si    <= rddata;
          r_j     <= w_jn;
          addr    <= w_jn;
          r_state <= S_RD_J;
        end
        S_RD_J: begin
          r_state <= S_LAT_J;
        end
        // rddata here is S[j]; it goes straight out as the S[i] write data.
        S_LAT_J: begin
          addr    <= r_i;
          wrdata  <= rddata;
          wren    <= 1'b1;
          r_state <= S_WR_I;
        end
        S_WR_I: begin
          addr    <= r_j;
          wrdata  <= r_si;
          r_state <= S_WR_J;
        end
        S_WR_J: begin
          wren <= 1'b0;
          if (r_i == 8'd255) begin
            r_state <= S_IDLE;
            rdy     <= 1'b1;
            addr    <= 8'd0;
          end else begin
            r_i     <= r_i + 8'd1;
            addr    <= r_i + 8'd1;
            r_kidx  <= (r_kidx == KW'(KEY_BYTES-1)) ? '0 : r_kidx + 1'b1;
            r_state <= S_RD_I;
          end
        end
        default: begin
          r_state <= S_IDLE;
          rdy     <= 1'b1;
          wren    <= 1'b0;
          addr    <= 8'd0;
        end
      endcase
    end
  end

`ifdef KSA_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= 16'd0;
    end else if (rdy && en) begin
      cycles <= 16'd0;
    end else if (!rdy) begin
      cycles <= cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ksa.sv
// tb/tb_ksa.sv - self-checking bench for ksa with an RC4 KSA reference model and S memory.
module tb_ksa;

  typedef logic [7:0] sarr_t [256];

  logic        clk;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;
`ifdef KSA_CYCLE_COUNT_EN
  logic [15:0] cycles;
`endif

  ksa #(.KEY_BYTES(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
`ifdef KSA_CYCLE_COUNT_EN
    ,
    .cycles (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sarr_t mem;
  logic  init_id;

  always @(posedge clk) begin
    if (init_id) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] kbyte(input logic [23:0] k, input int idx);
    return k[8*(2-idx) +: 8];
  endfunction

  function automatic sarr_t rc4(input sarr_t s_in, input logic [23:0] k);
    sarr_t s;
    logic [7:0] j;
    logic [7:0] t;
    s = s_in;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      j = 8'(j + s[i] + kbyte(k, i % 3));
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    return s;
  endfunction

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          busy_left = 0;
  logic        chk_on = 1'b0;

  // Reference model: predicts rdy and the exact write stream of each accepted run.
  always @(negedge clk) begin
    sarr_t s;
    logic [7:0] j;
    logic [7:0] t;
    logic [15:0] w;
    if (chk_on) begin
      chk("rdy", {31'd0, rdy}, {31'd0, (busy_left == 0)});
      if (wren) begin
        obs_q.push_back({addr, wrdata});
        if (exp_q.size() == 0) begin
          chk("unexpected_wren", {24'd0, addr}, 32'hffff_ffff);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", {24'd0, addr}, {24'd0, w[15:8]});
          chk("wr_data", {24'd0, wrdata}, {24'd0, w[7:0]});
        end
      end
      if (rst) begin
        busy_left = 0;
        exp_q.delete();
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (en) begin
        busy_left = 1536;
        s = mem;
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
          j = 8'(j + s[i] + kbyte(key, i % 3));
          exp_q.push_back({8'(i), s[j]});
          exp_q.push_back({j, s[i]});
          t = s[i]; s[i] = s[j]; s[j] = t;
        end
      end
    end
  end

  task automatic init_identity();
    @(posedge clk); #2 init_id = 1'b1;
    @(posedge clk); #2 init_id = 1'b0;
  endtask

  task automatic start(input logic [23:0] k);
    @(posedge clk); #2 key = k; en = 1'b1;
    @(posedge clk); #2 en = 1'b0;
  endtask

  task automatic wait_idle(output int low);
    low = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rdy === 1'b1) return;
      low++;
    end
    chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_mem(input string nm, input sarr_t exp);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp[i]) bad++;
    chk(nm, bad, 0);
  endtask

  initial begin
    sarr_t id_s;
    sarr_t exp_s;
    sarr_t res_a;
    bit    seen [256];
    int    low;
    int    dup;
    logic [15:0] lit6 [6];
    logic [15:0] lit4 [4];

    lit6 = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
    lit4 = '{16'h0001, 16'h0100, 16'h0103, 16'h0300};
    for (int i = 0; i < 256; i++) id_s[i] = 8'(i);

    rst = 1'b1; en = 1'b0; key = 24'd0; init_id = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset_rdy", {31'd0, rdy}, 32'd1);
    chk("reset_wren", {31'd0, wren}, 32'd0);
    chk("reset_addr", {24'd0, addr}, 32'd0);

    // Zero key: first six writes hand-computed.
    init_identity();
    obs_q.delete();
    start(24'h000000);
    wait_idle(low);
    chk("k0_len", obs_q.size(), 512);
    for (int n = 0; n < 6; n++) chk($sformatf("k0_wr%0d", n), {16'd0, obs_q[n]}, {16'd0, lit6[n]});

    init_identity();
    obs_q.delete();
    start(24'h010203);
    wait_idle(low);
    for (int n = 0; n < 4; n++) chk($sformatf("k123_wr%0d", n), {16'd0, obs_q[n]}, {16'd0, lit4[n]});

    // Full run against the model, busy length and permutation property.
    init_identity();
    start(24'h00033C);
    wait_idle(low);
    chk("busy_len", low, 1536);
    exp_s = rc4(id_s, 24'h00033C);
    chk_mem("full_run_s", exp_s);
    foreach (seen[i]) seen[i] = 1'b0;
    dup = 0;
    for (int i = 0; i < 256; i++) begin
      if (seen[mem[i]]) dup++;
      seen[mem[i]] = 1'b1;
    end
    chk("permutation", dup, 0);
`ifdef KSA_CYCLE_COUNT_EN
    chk("cycles_done", {16'd0, cycles}, 32'd1536);
    repeat (5) @(negedge clk);
    chk("cycles_hold", {16'd0, cycles}, 32'd1536);
`endif

    // en held high, key changed mid-run: back-to-back runs with distinct keys.
    init_identity();
    @(posedge clk); #2 key = 24'h123456; en = 1'b1;
    repeat (100) @(posedge clk);
    #2 key = 24'hABCDEF;
    wait_idle(low);
    res_a = rc4(id_s, 24'h123456);
    chk_mem("run_a_s", res_a);
    @(posedge clk); #2 en = 1'b0;
    @(negedge clk);
    chk("run_b_started", {31'd0, rdy}, 32'd0);
`ifdef KSA_CYCLE_COUNT_EN
    chk("cycles_cleared", {16'd0, cycles}, 32'd0);
`endif
    wait_idle(low);
    chk_mem("run_b_s", rc4(res_a, 24'hABCDEF));

    // Reset mid-run aborts with no further writes.
    init_identity();
    start(24'h00033C);
    repeat (50) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_rdy", {31'd0, rdy}, 32'd1);
    chk("abort_wren", {31'd0, wren}, 32'd0);
    repeat (20) @(negedge clk);

    // rst and en on the same edge: reset wins.
    @(posedge clk); #2 rst = 1'b1; en = 1'b1;
    @(posedge clk); #2 rst = 1'b0; en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_en_rdy", {31'd0, rdy}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ksa.md
Name: ksa

Overview:
- RC4 key-scheduling stage; sits directly downstream of the S-array init stage (S[i]=i).
- On a ready/enable handshake it permutes the 256-byte S memory in place:
  for i in 0..255 { j = (j + S[i] + key[i mod KEY_BYTES]) mod 256; swap S[i], S[j] }.
- It drives the same single-port S memory (256x8, 1-cycle registered read) that the init stage writes. The top level muxes the memory port to whichever stage is running.

Parameters:
- KEY_BYTES, 3, number of key bytes. Key port width is 8*KEY_BYTES. Byte 0 is the most significant byte.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  synchronous, active-high reset
- en  in  1  start request; accepted only on a rising edge where rdy=1 and en=1
- rdy  out  1  high when idle and able to accept en
- key  in  8*KEY_BYTES  RC4 key; captured into a register at acceptance
- addr  out  8  S memory address
- rddata  in  8  S memory read data; valid in the cycle after addr is presented with wren=0
- wrdata  out  8  S memory write data
- wren  out  1  S memory write enable

Behaviour:
- Reset (sync, rst=1 at clock edge):
  - state=IDLE; rdy=1, wren=0, addr=0, wrdata=0.
  - Internal i=0, j=0, key index=0.
  - Reset mid-run aborts immediately. S is left partially permuted; the block does not restore it.
- Handshake:
  - en is ignored while rdy=0. Holding en high in IDLE starts a new run on the next edge.
  - rdy falls in the cycle after acceptance and stays low for exactly 1536 cycles (256 iterations x 6 cycles).
  - rdy is back high in the 1537th cycle after the accepting edge.
  - At acceptance: j=0, i=0, key index=0, and key is registered. Later changes on the key port do not affect the run.
- FSM states: IDLE, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J. One cycle each.
  - IDLE: rdy=1, wren=0. Goes to RD_I on acceptance.
  - RD_I: addr=i, wren=0.
  - LAT_I: capture si=rddata; compute jn = j + si + keybyte[kidx], truncated to 8 bits.
  - RD_J: addr=jn, wren=0; register j=jn.
  - LAT_J: capture sj=rddata.
  - WR_I: addr=i, wrdata=sj, wren=1.
  - WR_J: addr=j, wrdata=si, wren=1. Then:
    - if i==255, go to IDLE;
    - else i++, kidx = (kidx==KEY_BYTES-1) ? 0 : kidx+1, and go to RD_I.
- Arithmetic:
  - All sums are mod 256 by 8-bit truncation; j wraps 255->0.
  - Key index is tracked with a wrapping counter, no divider.
- Boundaries:
  - i==j: both writes target the same address with the same value; no special case.
  - i=255: last iteration completes both writes before IDLE; i is not incremented past 255.
  - wren is high only in WR_I and WR_J. wren=0 in every other state, including IDLE.
  - rst and en asserted on the same edge: reset wins, run does not start.

Optional Feature:
- Macro: KSA_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycles (16 bits), cleared to 0 by reset and at acceptance.
  - Increments every cycle while rdy=0.
  - Holds its value in IDLE; equals 1536 after a complete run.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles, then release -> rdy=1, wren=0, addr=0. Pulse en mid-run, then rst -> rdy=1 on the cycle after the rst edge, and no further wren pulses.
- Init memory S[i]=i, key=24'h000000 -> first six writes in (addr, wrdata) order: (0,0), (0,0), (1,1), (1,1), (2,3), (3,2).
- Init S[i]=i, key=24'h010203 -> first four writes: (0,1), (1,0), (1,3), (3,0).
- Full run, key=24'h00033C, against a behavioural RC4 KSA model:
  - all 256 final S bytes match;
  - rdy is low for exactly 1536 cycles;
  - S remains a permutation of 0..255.
- Keep en=1 continuously and change key mid-run -> the second run starts on the first IDLE cycle and uses the key sampled at that acceptance. The first run's result matches the originally captured key.
- With KSA_CYCLE_COUNT_EN defined: after a full run, cycles=1536 and holds while idle. Starting a new run clears it to 0 at acceptance.
